// File: rtl/weight_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : weight_arb_pkg
//  Brief    : Shared types and helpers for the weight BRAM fetch arbiter:
//             FSM state enum, requester-ID width helper and burst descriptor.
//  Revision : 1.0 - initial release
// ============================================================================
package weight_arb_pkg;

    // Default configuration of the LSTM weight fetch path
    localparam int WFA_N_REQ      = 4;
    localparam int WFA_ADDR_WIDTH = 16;
    localparam int WFA_LEN_WIDTH  = 10;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wfa_state_e;

    // Width of a requester index; a single requester still needs one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_WIDTH = id_width(WFA_N_REQ);

    // One accepted burst as seen by the read sequencer
    typedef struct packed {
        logic [WFA_ADDR_WIDTH-1:0] base;
        logic [WFA_LEN_WIDTH-1:0]  len;
        logic [ID_WIDTH-1:0]       id;
    } burst_desc_t;

endpackage
`default_nettype wire

// File: rtl/wfa_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wfa_rr_arbiter
//  Brief    : Combinational N_REQ-way round-robin picker. Searches the request
//             vector starting at ptr and returns a one-hot grant plus the
//             encoded winner index. Purely combinational, no state.
//  Revision : 1.0 - initial release
// ============================================================================
module wfa_rr_arbiter
    import weight_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [N_REQ-1:0]    grant,
    output logic [ID_WIDTH-1:0] grant_idx
);

    logic w_found;
    int   w_idx;

    // First set request found walking upward (with wrap) from ptr wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(ptr) + k) % N_REQ;
            if (!w_found && req[w_idx]) begin
                w_found          = 1'b1;
                grant[w_idx]     = 1'b1;
                grant_idx        = w_idx[ID_WIDTH-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/weight_fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : weight_fetch_arbiter
//  Brief    : Round-robin scheduler sharing the weight BRAM read port among
//             N_REQ burst requesters. Accepts one (base, len) burst at a time,
//             issues one read address per cycle and returns the read data
//             tagged with requester ID and a last-word flag.
//             Optional macro WFA_BOUNDS_CHECK_EN: bursts running past MEM_SIZE
//             are accepted but dropped, and err_oob latches until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module weight_fetch_arbiter
    import weight_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_SIZE   = 36864,
    parameter int LEN_WIDTH  = 10,
    localparam int ID_WIDTH  = id_width(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_base,
    input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        bram_done,
    output logic                        bram_re,
    output logic [ADDR_WIDTH-1:0]       bram_rd_addr,
    input  logic [DATA_WIDTH-1:0]       bram_dout,
    output logic                        rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [ID_WIDTH-1:0]         rsp_id,
    output logic                        rsp_last,
    output logic                        busy,
    output logic                        err_oob
);

    localparam logic [0:0] c_st_idle  = ST_IDLE;
    localparam logic [0:0] c_st_burst = ST_BURST;

`ifdef WFA_BOUNDS_CHECK_EN
    localparam bit c_bounds_check_en = 1'b1;
`else
    localparam bit c_bounds_check_en = 1'b0;
`endif

    // End-of-burst limit in one extra bit so base+len never overflows
    localparam logic [ADDR_WIDTH:0] c_mem_limit = (ADDR_WIDTH+1)'(MEM_SIZE);

    logic [0:0]            r_state;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_rsp_valid;
    logic [ID_WIDTH-1:0]   r_rsp_id;
    logic                  r_rsp_last;

    logic [N_REQ-1:0]      w_grant;
    logic [ID_WIDTH-1:0]   w_grant_idx;
    logic [ID_WIDTH-1:0]   w_ptr_next;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_sel_base;
    logic [LEN_WIDTH-1:0]  w_sel_len;
    logic [ADDR_WIDTH:0]   w_end;
    logic                  w_oob;
    logic                  w_in_burst;
    logic                  w_last_issue;

    wfa_rr_arbiter #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Accept decision and winner's descriptor fields
    always_comb begin
        w_in_burst   = (r_state == c_st_burst);
        w_last_issue = w_in_burst && (r_cnt == LEN_WIDTH'(1));
        // rst_n gating keeps req_ready low while reset is held
        w_accept     = rst_n && bram_done && !w_in_burst && (|req_valid);
        w_sel_base   = req_base[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len    = req_len[w_grant_idx*LEN_WIDTH +: LEN_WIDTH];
        w_end        = {1'b0, w_sel_base}
                     + {{(ADDR_WIDTH+1-LEN_WIDTH){1'b0}}, w_sel_len};
        w_oob        = c_bounds_check_en && (w_end > c_mem_limit);
        w_ptr_next   = (w_grant_idx == ID_WIDTH'(N_REQ-1)) ? '0
                                                           : w_grant_idx + 1'b1;
    end

    // Burst FSM: latch descriptor on accept, then walk addresses down the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_ptr   <= '0;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_id    <= '0;
        end else if (!w_in_burst) begin
            if (w_accept) begin
                r_ptr <= w_ptr_next;
                r_cur <= w_sel_base;
                r_cnt <= w_sel_len;
                r_id  <= w_grant_idx;
                // Zero-length and out-of-range bursts are consumed without reads
                if ((w_sel_len != '0) && !w_oob) begin
                    r_state <= c_st_burst;
                end
            end
        end else begin
            r_cur <= r_cur + 1'b1;
            r_cnt <= r_cnt - 1'b1;
            if (w_last_issue) begin
                r_state <= c_st_idle;
            end
        end
    end

    // Response tags follow the issued read by one cycle, matching BRAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_rsp_valid <= w_in_burst;
            r_rsp_id    <= r_id;
            r_rsp_last  <= w_last_issue;
        end
    end

`ifdef WFA_BOUNDS_CHECK_EN
    logic r_err;

    // Sticky flag for any accepted burst that would run past the BRAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && w_oob) begin
            r_err <= 1'b1;
        end
    end

    assign err_oob = r_err;
`else
    assign err_oob = 1'b0;
`endif

    assign req_ready    = {N_REQ{w_accept}} & w_grant;
    assign bram_re      = w_in_burst;
    assign bram_rd_addr = r_cur;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = bram_dout;
    assign rsp_id       = r_rsp_id;
    assign rsp_last     = r_rsp_last;
    assign busy         = w_in_burst || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weight_fetch_arbiter
//  Brief    : Self-checking bench for weight_fetch_arbiter: directed scenarios
//             plus randomized traffic against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_weight_fetch_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int LW = 10;
    localparam int DW = 32;
    localparam int MEMSZ = 36864;
`ifdef WFA_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_base = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    req_ready;
    logic            bram_done = 1'b1;
    logic            bram_re;
    logic [AW-1:0]   bram_rd_addr;
    logic [DW-1:0]   bram_dout = '0;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_id;
    logic            rsp_last;
    logic            busy;
    logic            err_oob;

    int n_cmp = 0;
    int n_err = 0;

    weight_fetch_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_base     (req_base),
        .req_len      (req_len),
        .req_ready    (req_ready),
        .bram_done    (bram_done),
        .bram_re      (bram_re),
        .bram_rd_addr (bram_rd_addr),
        .bram_dout    (bram_dout),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_last     (rsp_last),
        .busy         (busy),
        .err_oob      (err_oob)
    );

    always #5 clk = ~clk;

    // Deterministic BRAM contents, one-cycle read latency
    function automatic logic [31:0] memf(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a} + 32'h0F0F_1234;
    endfunction

    always @(posedge clk) begin
        if (bram_re) bram_dout <= memf(bram_rd_addr);
    end

    // Round-robin rule: first pending requester at or after p (cyclic)
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input int base, input int len);
        req_base[i*AW +: AW] = AW'(base);
        req_len[i*LW +: LW]  = LW'(len);
        req_valid[i]         = 1'b1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        bram_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bram_done = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 16'h0010 * i, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        n_cmp++;
        if ({bram_re, rsp_valid, rsp_last, busy, err_oob} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000",
                              {bram_re, rsp_valid, rsp_last, busy, err_oob});
        end
        n_cmp++;
        if ({bram_rd_addr, rsp_id} !== 18'h0) begin
            n_err++; $display("FAIL reset_addr_id: got %h expected 0", {bram_rd_addr, rsp_id});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
        end
    endtask

    task automatic test_single();
        int L = 4;
        logic [15:0] b = 16'h0100;
        apply_reset();
        @(posedge clk); #1 set_req(2, b, L);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL single_ready: got %b expected 0100", req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        for (int t = 1; t <= L + 2; t++) begin
            logic [15:0] ea = b + 16'(t - 1);
            logic [15:0] da = b + 16'(t - 2);
            @(negedge clk);
            n_cmp++;
            if (bram_re !== (t <= L) || (t <= L && bram_rd_addr !== ea)) begin
                n_err++; $display("FAIL single_issue t=%0d: got re=%b addr=%h expected re=%b addr=%h",
                                  t, bram_re, bram_rd_addr, (t <= L), ea);
            end
            n_cmp++;
            if (rsp_valid !== (t >= 2 && t <= L + 1)) begin
                n_err++; $display("FAIL single_rsp_valid t=%0d: got %b", t, rsp_valid);
            end
            if (t >= 2 && t <= L + 1) begin
                n_cmp++;
                if (rsp_data !== memf(da) || rsp_id !== 2'd2 || rsp_last !== (t == L + 1)) begin
                    n_err++; $display("FAIL single_rsp t=%0d: got data=%h id=%0d last=%b expected data=%h id=2 last=%b",
                                      t, rsp_data, rsp_id, rsp_last, memf(da), (t == L + 1));
                end
            end
            n_cmp++;
            if (busy !== (t <= L + 1)) begin
                n_err++; $display("FAIL single_busy t=%0d: got %b expected %b", t, busy, (t <= L + 1));
            end
        end
    endtask

    task automatic test_all_four();
        int gcyc[$];
        int gidx[$];
        int rid[$];
        logic [31:0] rdat[$];
        bit rlast[$];
        logic [N-1:0] tk;
        apply_reset();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 16'h1000 * (i + 1), 2);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tk = req_valid & req_ready;
            if (tk != '0) begin
                gcyc.push_back(c);
                gidx.push_back($clog2(tk));
            end
            if (rsp_valid) begin
                rid.push_back(int'(rsp_id));
                rdat.push_back(rsp_data);
                rlast.push_back(rsp_last);
            end
            @(posedge clk); #1 req_valid = req_valid & ~tk;
        end
        n_cmp++;
        if (gidx.size() != 4) begin
            n_err++; $display("FAIL four_grant_count: got %0d expected 4", gidx.size());
        end
        for (int k = 0; k < gidx.size() && k < 4; k++) begin
            n_cmp++;
            if (gidx[k] != k || gcyc[k] != 3 * k) begin
                n_err++; $display("FAIL four_grant_%0d: got id=%0d cycle=%0d expected id=%0d cycle=%0d",
                                  k, gidx[k], gcyc[k], k, 3 * k);
            end
        end
        n_cmp++;
        if (rid.size() != 8) begin
            n_err++; $display("FAIL four_rsp_count: got %0d expected 8", rid.size());
        end
        for (int k = 0; k < rid.size() && k < 8; k++) begin
            logic [15:0] a = 16'h1000 * 16'(k / 2 + 1) + 16'(k % 2);
            n_cmp++;
            if (rid[k] != k / 2 || rdat[k] !== memf(a) || rlast[k] != (k % 2 == 1)) begin
                n_err++; $display("FAIL four_rsp_%0d: got id=%0d data=%h last=%b expected id=%0d data=%h last=%b",
                                  k, rid[k], rdat[k], rlast[k], k / 2, memf(a), (k % 2 == 1));
            end
        end
    endtask

    task automatic test_fairness();
        int order[$];
        int g1 = 0;
        logic [N-1:0] tk;
        apply_reset();
        @(posedge clk); #1;
        set_req(1, 16'h0300, 1);
        set_req(3, 16'h0500, 1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            tk = req_valid & req_ready;
            if (tk != '0) order.push_back($clog2(tk));
            @(posedge clk); #1;
            if (tk[1]) begin
                g1++;
                if (g1 > 1) req_valid[1] = 1'b0;
            end
            if (tk[3]) req_valid[3] = 1'b0;
        end
        n_cmp++;
        if (order.size() < 3) begin
            n_err++; $display("FAIL fair_count: got %0d expected 3", order.size());
        end else begin
            n_cmp++;
            if (order[0] != 1 || order[1] != 3 || order[2] != 1) begin
                n_err++; $display("FAIL fair_order: got %0d,%0d,%0d expected 1,3,1",
                                  order[0], order[1], order[2]);
            end
        end
    endtask

    task automatic test_len0();
        apply_reset();
        @(posedge clk); #1 set_req(0, 16'h0040, 0);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL len0_ready: got %b expected 0001", req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            n_cmp++;
            if ({bram_re, rsp_valid, busy} !== 3'b000) begin
                n_err++; $display("FAIL len0_idle t=%0d: got %b expected 000", t, {bram_re, rsp_valid, busy});
            end
        end
        @(posedge clk); #1;
        set_req(0, 16'h0050, 1);
        set_req(1, 16'h0060, 1);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++; $display("FAIL len0_ptr: got %b expected 0010", req_ready);
        end
    endtask

    task automatic test_bram_done();
        apply_reset();
        @(posedge clk); #1;
        bram_done = 1'b0;
        set_req(1, 16'h0700, 1);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_err++; $display("FAIL done_low t=%0d: got %b expected 0000", t, req_ready);
            end
            @(posedge clk); #1;
        end
        bram_done = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++; $display("FAIL done_rise: got %b expected 0010", req_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        @(posedge clk); #1 set_req(0, 16'h0200, 8);
        @(negedge clk);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bram_re, rsp_valid, busy} !== 3'b111 || bram_rd_addr !== 16'h0201) begin
            n_err++; $display("FAIL midrst_pre: got %b addr=%h expected 111 addr=0201",
                              {bram_re, rsp_valid, busy}, bram_rd_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bram_re, rsp_valid, busy, rsp_last} !== 4'b0000 || bram_rd_addr !== 16'h0) begin
            n_err++; $display("FAIL midrst_clear: got %b addr=%h expected 0000 addr=0000",
                              {bram_re, rsp_valid, busy, rsp_last}, bram_rd_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 16'h0200, 8);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL midrst_regrant: got %b expected 0001", req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (bram_re !== 1'b1 || bram_rd_addr !== 16'h0200) begin
            n_err++; $display("FAIL midrst_restart: got re=%b addr=%h expected re=1 addr=0200",
                              bram_re, bram_rd_addr);
        end
    endtask

`ifdef WFA_BOUNDS_CHECK_EN
    task automatic test_range();
        apply_reset();
        @(posedge clk); #1 set_req(2, 36860, 8);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL oob_ready: got %b expected 0100", req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            n_cmp++;
            if ({bram_re, rsp_valid, err_oob} !== 3'b001) begin
                n_err++; $display("FAIL oob_state t=%0d: got %b expected 001", t, {bram_re, rsp_valid, err_oob});
            end
        end
        @(posedge clk); #1;
        set_req(1, 16'h0010, 1);
        set_req(3, 16'h0020, 1);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b1000 || err_oob !== 1'b1) begin
            n_err++; $display("FAIL oob_ptr: got ready=%b err=%b expected ready=1000 err=1", req_ready, err_oob);
        end
    endtask
`else
    task automatic test_range();
        apply_reset();
        @(posedge clk); #1 set_req(2, 16'hFFFE, 4);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL wrap_ready: got %b expected 0100", req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        for (int t = 1; t <= 4; t++) begin
            logic [15:0] ea = 16'hFFFE + 16'(t - 1);
            @(negedge clk);
            n_cmp++;
            if (bram_re !== 1'b1 || bram_rd_addr !== ea || err_oob !== 1'b0) begin
                n_err++; $display("FAIL wrap_addr t=%0d: got re=%b addr=%h err=%b expected re=1 addr=%h err=0",
                                  t, bram_re, bram_rd_addr, err_oob, ea);
            end
        end
    endtask
`endif

    // Randomized traffic against a burst-level model of the scheduling rules
    task automatic test_random();
        int free_at = 0;
        int mptr = 0;
        logic [15:0] q_addr[$];
        int q_id[$];
        bit q_last[$];
        bit pv = 1'b0;
        logic [15:0] pa = '0;
        int pid = 0;
        bit plast = 1'b0;
        bit exp_err = 1'b0;
        logic [N-1:0] tk = '0;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [N-1:0] exp_rdy;
            int w;
            bit er;
            logic [15:0] ea;
            int eid;
            bit el;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (tk[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, int'($urandom_range(0, 65535)),
                            ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 40))
                                                        : int'($urandom_range(0, 5)));
                end
            end
            bram_done = ($urandom_range(0, 9) != 0);
            @(negedge clk);
            exp_rdy = '0;
            w = -1;
            if (cyc >= free_at && bram_done && (|req_valid)) begin
                w = rr_pick(req_valid, mptr);
                exp_rdy[w] = 1'b1;
            end
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_err++; $display("FAIL rnd_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_rdy);
            end
            er = 1'b0; ea = '0; eid = 0; el = 1'b0;
            if (q_addr.size() > 0) begin
                er = 1'b1;
                ea = q_addr.pop_front();
                eid = q_id.pop_front();
                el = q_last.pop_front();
            end
            n_cmp++;
            if (bram_re !== er || (er && bram_rd_addr !== ea)) begin
                n_err++; $display("FAIL rnd_issue cyc=%0d: got re=%b addr=%h expected re=%b addr=%h",
                                  cyc, bram_re, bram_rd_addr, er, ea);
            end
            n_cmp++;
            if (rsp_valid !== pv || (pv && (rsp_data !== memf(pa) || rsp_id !== pid[1:0] || rsp_last !== plast))) begin
                n_err++; $display("FAIL rnd_rsp cyc=%0d: got v=%b data=%h id=%0d last=%b expected v=%b data=%h id=%0d last=%b",
                                  cyc, rsp_valid, rsp_data, rsp_id, rsp_last, pv, memf(pa), pid, plast);
            end
            n_cmp++;
            if (busy !== (er || pv) || err_oob !== exp_err) begin
                n_err++; $display("FAIL rnd_status cyc=%0d: got busy=%b err=%b expected busy=%b err=%b",
                                  cyc, busy, err_oob, (er || pv), exp_err);
            end
            pv = er; pa = ea; pid = eid; plast = el;
            tk = req_valid & req_ready;
            if (w >= 0) begin
                int L = int'(req_len[w*LW +: LW]);
                int B = int'(req_base[w*AW +: AW]);
                bit oob = BC && (B + L > MEMSZ);
                mptr = (w + 1) % N;
                if (oob) exp_err = 1'b1;
                if (L > 0 && !oob) begin
                    for (int k = 0; k < L; k++) begin
                        q_addr.push_back(16'((B + k) % 65536));
                        q_id.push_back(w);
                        q_last.push_back(k == L - 1);
                    end
                    free_at = cyc + L + 1;
                end else begin
                    free_at = cyc + 1;
                end
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_len0();
        test_bram_done();
        test_reset_mid_burst();
        test_range();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
